// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DROP,
        STOP,
        HALTED
    } state_t;

    localparam logic [15:0] HALT_WORD = 16'hFFFF;
    localparam logic [15:0] PC_STEP   = 16'd2;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous instruction queue holding {pc, instr} pairs; flush empties it in one edge.
module fetch_queue #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only read after it was written, and the top gates the empty head.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a decode queue,
// with redirect flush and a sticky halt on the all-ones instruction word.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    localparam int          CW       = $clog2(DEPTH) + 1;
    localparam logic [15:0] START_PC = RESET_PC & 16'hFFFE;

    state_t        state, state_n;
    logic [15:0]   fetch_pc, pc_n;
    logic [15:0]   addr_n, issue_pc, target;
    logic          req_n, issue;
    logic          fetch, pop, push, flush;
    logic [31:0]   q_rdata;
    logic [CW-1:0] q_count;
    logic          q_full, q_empty;
    int            entries_after;

    assign fetch       = imem_req && imem_ack;
    assign pop         = instr_valid && instr_ready;
    assign target      = redirect_pc & 16'hFFFE;
    assign instr_valid = !q_empty && (state != HALTED);
    assign instr       = instr_valid ? q_rdata[15:0]  : 16'h0000;
    assign instr_pc    = instr_valid ? q_rdata[31:16] : 16'h0000;
    assign halted      = (state == HALTED);

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop && !redirect),
        .flush   (flush),
        .wdata   ({imem_addr, imem_data}),
        .rdata   (q_rdata),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n       = state;
        req_n         = imem_req;
        addr_n        = imem_addr;
        pc_n          = fetch_pc;
        push          = 1'b0;
        flush         = 1'b0;
        issue         = 1'b0;
        issue_pc      = fetch_pc;
        entries_after = int'(q_count) - int'(pop);

        if (state == HALTED) begin
            req_n = 1'b0;
        end else if (redirect) begin
            flush = 1'b1;
            if (imem_req && !imem_ack) begin
                // Request still in flight: hold it stable and discard its data on arrival.
                state_n = DROP;
                pc_n    = target;
            end else begin
                issue    = 1'b1;
                issue_pc = target;
            end
        end else begin
            case (state)
                IDLE: if (entries_after < DEPTH) issue = 1'b1;
                WAIT: begin
                    if (fetch) begin
                        push = !q_full;
                        if (imem_data == HALT_WORD) begin
                            state_n = STOP;
                            req_n   = 1'b0;
                        end else if (entries_after + 1 < DEPTH) begin
                            issue = 1'b1;
                        end else begin
                            state_n = IDLE;
                            req_n   = 1'b0;
                        end
                    end
                end
                DROP: if (fetch) issue = 1'b1;
                STOP: if (pop && instr == HALT_WORD) state_n = HALTED;
                default: ;
            endcase
        end

        if (issue) begin
            state_n = WAIT;
            req_n   = 1'b1;
            addr_n  = issue_pc;
            pc_n    = issue_pc + PC_STEP;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= START_PC;
            fetch_pc  <= START_PC;
        end else begin
            state     <= state_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            fetch_pc  <= pc_n;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a bench-driven instruction memory.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    int          total = 0;
    int          bad   = 0;
    int          acks  = 0;
    int          over  = 0;
    bit          auto_ack;
    bit          halt_en;
    bit          watch;
    logic [15:0] halt_addr;

    fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return (halt_en && a == halt_addr) ? 16'hFFFF : (a ^ 16'hA500);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: count the fetch about to happen, then sample and drive #1 after the edge.
    task automatic tick();
        if (imem_req && imem_ack) acks++;
        @(posedge clock);
        #1;
        if (watch && imem_req && imem_addr > 16'h0006) over++;
        if (auto_ack) begin
            imem_ack  = imem_req;
            imem_data = word_of(imem_addr);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        imem_data   = 16'h0000;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        auto_ack    = 1'b0;
        halt_en     = 1'b0;
        watch       = 1'b0;
        acks        = 0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        halt_addr   = 16'h0006;
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        imem_data   = 16'h0000;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        #12;
        check("rst_req",    16'(imem_req),    16'h0);
        check("rst_addr",   imem_addr,        16'h0000);
        check("rst_valid",  16'(instr_valid), 16'h0);
        check("rst_instr",  instr,            16'h0000);
        check("rst_pc",     instr_pc,         16'h0000);
        check("rst_halted", 16'(halted),      16'h0);

        // Zero-wait streaming with decode always ready.
        do_reset();
        instr_ready = 1'b1;
        auto_ack    = 1'b1;
        tick();
        check("stream_first_req",  16'(imem_req), 16'h1);
        check("stream_first_addr", imem_addr,     16'h0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stream_pc",    instr_pc,         16'(2 * k));
            check("stream_instr", instr,            16'(2 * k) ^ 16'hA500);
            check("stream_valid", 16'(instr_valid), 16'h1);
            check("stream_req",   16'(imem_req),    16'h1);
            check("stream_addr",  imem_addr,        16'(2 * k + 2));
        end

        // Back-pressure: queue fills after four acks, one pop frees one request.
        do_reset();
        auto_ack = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("full_acks",  16'(acks),        16'h4);
        check("full_req",   16'(imem_req),    16'h0);
        check("full_valid", 16'(instr_valid), 16'h1);
        check("full_head",  instr_pc,         16'h0000);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("refill_req",  16'(imem_req), 16'h1);
        check("refill_addr", imem_addr,     16'h0008);
        check("refill_head", instr_pc,      16'h0002);

        // Redirect while a request waits: late data dropped, target refetched.
        do_reset();
        instr_ready = 1'b1;
        tick();
        check("wait_req", 16'(imem_req), 16'h1);
        redirect    = 1'b1;
        redirect_pc = 16'h0021;
        tick();
        redirect = 1'b0;
        check("drop_req_hold",  16'(imem_req),    16'h1);
        check("drop_addr_hold", imem_addr,        16'h0000);
        check("drop_valid",     16'(instr_valid), 16'h0);
        tick();
        tick();
        check("drop_still_addr", imem_addr, 16'h0000);
        imem_ack  = 1'b1;
        imem_data = word_of(16'h0000);
        tick();
        check("drop_discard_valid", 16'(instr_valid), 16'h0);
        check("redir_req",          16'(imem_req),    16'h1);
        check("redir_addr",         imem_addr,        16'h0020);
        imem_data = word_of(16'h0020);
        tick();
        imem_ack = 1'b0;
        check("redir_valid", 16'(instr_valid), 16'h1);
        check("redir_pc",    instr_pc,         16'h0020);
        check("redir_instr", instr,            16'h0020 ^ 16'hA500);

        // Halt word at address 6 stops fetching, then halts once consumed.
        do_reset();
        instr_ready = 1'b1;
        auto_ack    = 1'b1;
        halt_en     = 1'b1;
        watch       = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        check("stop_pc",     instr_pc,    16'h0006);
        check("stop_instr",  instr,       16'hFFFF);
        check("stop_req",    16'(imem_req), 16'h0);
        check("stop_halted", 16'(halted), 16'h0);
        tick();
        check("halt_flag",  16'(halted),      16'h1);
        check("halt_valid", 16'(instr_valid), 16'h0);
        check("halt_req",   16'(imem_req),    16'h0);
        redirect    = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        tick();
        check("halt_ign_req",    16'(imem_req),    16'h0);
        check("halt_ign_flag",   16'(halted),      16'h1);
        check("halt_ign_valid",  16'(instr_valid), 16'h0);
        check("halt_no_beyond6", 16'(over),        16'h0);

        // Redirect coincident with ack, to the top of the address space.
        do_reset();
        instr_ready = 1'b1;
        auto_ack    = 1'b1;
        tick();
        tick();
        check("wrap_pre_pc", instr_pc, 16'h0000);
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        check("wrap_flush_valid", 16'(instr_valid), 16'h0);
        check("wrap_addr0",       imem_addr,        16'hFFFE);
        tick();
        check("wrap_addr1", imem_addr, 16'h0000);
        check("wrap_pc1",   instr_pc,  16'hFFFE);
        tick();
        check("wrap_addr2", imem_addr, 16'h0002);
        check("wrap_pc2",   instr_pc,  16'h0000);

        // Reset mid-request with an ack pending.
        do_reset();
        auto_ack = 1'b1;
        tick();
        tick();
        tick();
        auto_ack = 1'b0;
        imem_ack = 1'b0;
        tick();
        check("mid_req",   16'(imem_req), 16'h1);
        check("mid_addr",  imem_addr,     16'h0004);
        imem_ack  = 1'b1;
        imem_data = word_of(16'h0004);
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_req",    16'(imem_req),    16'h0);
        check("mrst_addr",   imem_addr,        16'h0000);
        check("mrst_valid",  16'(instr_valid), 16'h0);
        check("mrst_instr",  instr,            16'h0000);
        check("mrst_pc",     instr_pc,         16'h0000);
        check("mrst_halted", 16'(halted),      16'h0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("mrel_req",   16'(imem_req),    16'h1);
        check("mrel_addr",  imem_addr,        16'h0000);
        check("mrel_valid", 16'(instr_valid), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
